fetch_ctrl: RTL and testbench



---
 rtl/pipe_pkg.sv | 14 +
 rtl/fetch_ctrl_if.sv | 36 +++
 rtl/hazard_detect.sv | 16 +
 rtl/fetch_ctrl.sv | 87 ++++++++
 tb/tb_fetch_ctrl.sv | 153 +++++++++++++++
 5 files changed

// File: rtl/pipe_pkg.sv
// Shared pipeline definitions: fetch sequencer states, register-zero index and PC width.
package pipe_pkg;

  localparam int unsigned PC_W = 32;
  localparam logic [4:0] REG_ZERO = 5'd0;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    STALL = 2'd1,
    FLUSH = 2'd2,
    HALT  = 2'd3
  } fetch_state_e;

endpackage

// File: rtl/fetch_ctrl_if.sv
// Pipeline-side hazard/redirect inputs and fetch control outputs of fetch_ctrl.
interface fetch_ctrl_if #(
  parameter int unsigned CNT_W = 32
);
  import pipe_pkg::*;

  logic             ex_mem_pcsrc;
  logic [PC_W-1:0]  ex_mem_npc;
  logic             id_ex_memread;
  logic [4:0]       id_ex_rt;
  logic [4:0]       if_id_rs;
  logic [4:0]       if_id_rt;
  logic             halt_req;
  logic [PC_W-1:0]  pc;
  logic             pc_write;
  logic             if_id_write;
  logic             if_id_flush;
  logic             id_ex_flush;
  logic             ex_mem_flush;
  logic             halted;
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] flush_cnt;

  modport master (
    output ex_mem_pcsrc, ex_mem_npc, id_ex_memread, id_ex_rt, if_id_rs, if_id_rt, halt_req,
    input  pc, pc_write, if_id_write, if_id_flush, id_ex_flush, ex_mem_flush, halted,
           stall_cnt, flush_cnt
  );

  modport slave (
    input  ex_mem_pcsrc, ex_mem_npc, id_ex_memread, id_ex_rt, if_id_rs, if_id_rt, halt_req,
    output pc, pc_write, if_id_write, if_id_flush, id_ex_flush, ex_mem_flush, halted,
           stall_cnt, flush_cnt
  );

endinterface

// File: rtl/hazard_detect.sv
// Load-use hazard compare between the load in EX and the source registers in ID.
module hazard_detect
  import pipe_pkg::*;
(
  input  logic       id_ex_memread,
  input  logic [4:0] id_ex_rt,
  input  logic [4:0] if_id_rs,
  input  logic [4:0] if_id_rt,
  output logic       load_use
);

  // Loads into r0 never create a dependency.
  assign load_use = id_ex_memread && (id_ex_rt != REG_ZERO) &&
                    ((id_ex_rt == if_id_rs) || (id_ex_rt == if_id_rt));

endmodule

// File: rtl/fetch_ctrl.sv
// Front-end sequencer: owns the PC and resolves redirect/halt/load-use stalls each cycle.
module fetch_ctrl
  import pipe_pkg::*;
#(
  parameter logic [PC_W-1:0] RESET_PC = 32'h0000_0000,
  parameter logic [PC_W-1:0] PC_STEP  = 32'd1,
  parameter int unsigned     CNT_W    = 32
) (
  input  logic      clk,
  input  logic      rst_n,
  fetch_ctrl_if.slave bus
);

  fetch_state_e     state_q, state_d;
  logic [PC_W-1:0]  pc_q, pc_d;
  logic [CNT_W-1:0] stall_cnt_q, flush_cnt_q;
  logic             stall_inc, flush_inc;
  logic             load_use;

  hazard_detect u_hazard_detect (
    .id_ex_memread (bus.id_ex_memread),
    .id_ex_rt      (bus.id_ex_rt),
    .if_id_rs      (bus.if_id_rs),
    .if_id_rt      (bus.if_id_rt),
    .load_use      (load_use)
  );

  always_comb begin
    state_d          = RUN;
    pc_d             = pc_q;
    stall_inc        = 1'b0;
    flush_inc        = 1'b0;
    bus.pc_write     = 1'b0;
    bus.if_id_write  = 1'b0;
    bus.if_id_flush  = 1'b0;
    bus.id_ex_flush  = 1'b0;
    bus.ex_mem_flush = 1'b0;
    case (state_q)
      HALT: state_d = HALT;
      // RUN, STALL, FLUSH and any corrupted encoding share the priority chain.
      default: begin
        if (bus.ex_mem_pcsrc) begin
          bus.pc_write     = 1'b1;
          bus.if_id_write  = 1'b1;
          bus.if_id_flush  = 1'b1;
          bus.id_ex_flush  = 1'b1;
          bus.ex_mem_flush = 1'b1;
          pc_d             = bus.ex_mem_npc;
          flush_inc        = 1'b1;
          state_d          = FLUSH;
        end else if (bus.halt_req) begin
          bus.id_ex_flush = 1'b1;
          state_d         = HALT;
        end else if (load_use) begin
          bus.id_ex_flush = 1'b1;
          stall_inc       = 1'b1;
          state_d         = STALL;
        end else begin
          bus.pc_write    = 1'b1;
          bus.if_id_write = 1'b1;
          pc_d            = pc_q + PC_STEP;
          state_d         = RUN;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= RUN;
      pc_q        <= RESET_PC;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      if (stall_inc && (stall_cnt_q != '1)) stall_cnt_q <= stall_cnt_q + CNT_W'(1);
      if (flush_inc && (flush_cnt_q != '1)) flush_cnt_q <= flush_cnt_q + CNT_W'(1);
    end
  end

  assign bus.pc        = pc_q;
  assign bus.halted    = (state_q == HALT);
  assign bus.stall_cnt = stall_cnt_q;
  assign bus.flush_cnt = flush_cnt_q;

endmodule

// File: tb/tb_fetch_ctrl.sv
// Randomized and directed check of fetch_ctrl against a behavioural PC/hazard model.
module tb_fetch_ctrl;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  int unsigned n_checks = 0;
  int unsigned n_fails  = 0;

  fetch_ctrl_if #(.CNT_W(32)) bus ();
  fetch_ctrl_if #(.CNT_W(3))  bus_sat ();

  fetch_ctrl #(.RESET_PC(32'h0000_0000), .PC_STEP(32'd1), .CNT_W(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  fetch_ctrl #(.RESET_PC(32'h0000_0000), .PC_STEP(32'd1), .CNT_W(3)) dut_sat (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_sat)
  );

  assign bus_sat.ex_mem_pcsrc  = bus.ex_mem_pcsrc;
  assign bus_sat.ex_mem_npc    = bus.ex_mem_npc;
  assign bus_sat.id_ex_memread = bus.id_ex_memread;
  assign bus_sat.id_ex_rt      = bus.id_ex_rt;
  assign bus_sat.if_id_rs      = bus.if_id_rs;
  assign bus_sat.if_id_rt      = bus.if_id_rt;
  assign bus_sat.halt_req      = bus.halt_req;

  always #5 clk = ~clk;

  // Reference model: architectural PC, halt flag and raw event counts.
  logic [31:0] m_pc;
  bit          m_halted;
  int unsigned m_stalls, m_flushes;
  bit          m_valid = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] sat3(input int unsigned v);
    return (v > 7) ? 32'd7 : 32'(v);
  endfunction

  task automatic step(input bit rst, input bit pcsrc, input logic [31:0] npc,
                      input bit memrd, input logic [4:0] ldrt,
                      input logic [4:0] rs, input logic [4:0] rt, input bit halt);
    bit          e_pw, e_ifw, e_iff, e_idf, e_exf, lu, n_halted;
    logic [31:0] n_pc;
    int unsigned n_st, n_fl;
    rst_n             = ~rst;
    bus.ex_mem_pcsrc  = pcsrc;
    bus.ex_mem_npc    = npc;
    bus.id_ex_memread = memrd;
    bus.id_ex_rt      = ldrt;
    bus.if_id_rs      = rs;
    bus.if_id_rt      = rt;
    bus.halt_req      = halt;
    #1;
    lu = memrd && (ldrt != 0) && (ldrt == rs || ldrt == rt);
    {e_pw, e_ifw, e_iff, e_idf, e_exf} = '0;
    n_pc = m_pc; n_halted = m_halted; n_st = m_stalls; n_fl = m_flushes;
    if (m_halted) begin
      // nothing moves
    end else if (pcsrc) begin
      {e_pw, e_ifw, e_iff, e_idf, e_exf} = '1;
      n_pc = npc; n_fl++;
    end else if (halt) begin
      e_idf = 1; n_halted = 1;
    end else if (lu) begin
      e_idf = 1; n_st++;
    end else begin
      e_pw = 1; e_ifw = 1; n_pc = m_pc + 32'd1;
    end
    if (m_valid) begin
      check("pc",          bus.pc,           m_pc);
      check("pc_write",    32'(bus.pc_write),     32'(e_pw));
      check("if_id_write", 32'(bus.if_id_write),  32'(e_ifw));
      check("if_id_flush", 32'(bus.if_id_flush),  32'(e_iff));
      check("id_ex_flush", 32'(bus.id_ex_flush),  32'(e_idf));
      check("ex_mem_flush",32'(bus.ex_mem_flush), 32'(e_exf));
      check("halted",      32'(bus.halted),       32'(m_halted));
      check("stall_cnt",   bus.stall_cnt,    m_stalls);
      check("flush_cnt",   bus.flush_cnt,    m_flushes);
      check("sat_stall",   32'(bus_sat.stall_cnt), sat3(m_stalls));
      check("sat_flush",   32'(bus_sat.flush_cnt), sat3(m_flushes));
    end
    @(posedge clk);
    if (rst) begin
      m_pc = 32'h0; m_halted = 0; m_stalls = 0; m_flushes = 0; m_valid = 1;
    end else begin
      m_pc = n_pc; m_halted = n_halted; m_stalls = n_st; m_flushes = n_fl;
    end
    @(negedge clk);
  endtask

  task automatic idle();
    step(0, 0, 32'h0, 0, 5'd0, 5'd0, 5'd0, 0);
  endtask

  initial begin
    // reset, then free-run
    step(1, 0, 32'h0, 0, 0, 0, 0, 0);
    step(1, 1, 32'h9, 1, 5'd3, 5'd3, 5'd0, 1);
    repeat (3) idle();                              // pc 0,1,2
    step(0, 1, 32'd5, 0, 0, 0, 0, 0);               // redirect at pc=3
    idle(); idle();                                 // pc 5, 6
    step(0, 0, 32'h0, 1, 5'd8, 5'd8, 5'd1, 0);      // load-use stall at pc=7
    idle();
    step(0, 0, 32'h0, 1, 5'd0, 5'd0, 5'd0, 0);      // rt=0: no stall
    step(0, 0, 32'h0, 1, 5'd4, 5'd2, 5'd4, 0);      // rt match
    step(0, 1, 32'd20, 1, 5'd8, 5'd8, 5'd8, 0);     // redirect beats load-use
    idle();
    step(0, 1, 32'd7, 1, 5'd8, 5'd8, 5'd8, 1);      // redirect beats halt
    step(0, 0, 32'h0, 1, 5'd8, 5'd8, 5'd8, 1);      // halt at pc=7
    repeat (3) idle();
    step(0, 1, 32'd40, 0, 0, 0, 0, 0);              // ignored in HALT
    step(0, 0, 32'h0, 1, 5'd2, 5'd2, 5'd2, 0);
    step(1, 1, 32'd40, 0, 0, 0, 0, 1);              // reset leaves HALT
    idle();
    step(0, 1, 32'hFFFF_FFFF, 0, 0, 0, 0, 0);       // PC wrap
    idle(); idle();
    step(0, 1, 32'h10, 0, 0, 0, 0, 0);              // back-to-back redirects
    step(0, 1, 32'h30, 0, 0, 0, 0, 0);
    step(0, 0, 32'h0, 1, 5'd5, 5'd5, 5'd0, 0);      // back-to-back stalls
    step(0, 0, 32'h0, 1, 5'd5, 5'd0, 5'd5, 0);
    idle();

    for (int i = 0; i < 600; i++) begin
      bit r, ps, mr, h;
      logic [31:0] np;
      r  = m_halted ? ($urandom_range(0, 9) == 0) : ($urandom_range(0, 99) == 0);
      ps = ($urandom_range(0, 4) == 0);
      mr = ($urandom_range(0, 1) == 0);
      h  = ($urandom_range(0, 39) == 0);
      np = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFF : $urandom;
      step(r, ps, np, mr, 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
           5'($urandom_range(0, 7)), h);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
